sq_wave_sequencer: RTL
======================

Name: sq_wave_sequencer

Overview:
Controller that sequences the programmable square wave generator through a small table of (on, off) settings. Each entry is held for a programmed number of output periods. The block drives the generator's up/down control inputs and monitors its sq_wave output. New settings are applied only at period boundaries, so the waveform is reconfigured glitch-free. Sits between the top-level control logic and one square wave generator instance.

Parameters:
DEPTH, 4, number of table entries (power of 2, >= 2)
W, 4, width of up/down (on/off interval) fields
CW, 8, width of per-entry period count
AW, $clog2(DEPTH), table address width (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  1  table write strobe, accepted only in IDLE
wr_addr  in  AW  table entry index
wr_up  in  W  on-interval value for entry
wr_down  in  W  off-interval value for entry
wr_count  in  CW  periods to hold entry (0 treated as 1)
last_idx  in  AW  index of final step, sampled on accepted start
loop_en  in  1  1 = wrap to entry 0 after last_idx; sampled on accepted start
start  in  1  single-cycle start request
stop  in  1  abort request
sq_wave_in  in  1  generator output being monitored
up  out  W  to generator up input
down  out  W  to generator down input
busy  out  1  high in LOAD/RUN
done  out  1  one-cycle pulse on normal completion
cur_step  out  AW  index of entry currently applied

Behaviour:
- Reset (reset=0, async): state=IDLE; up=1, down=1, busy=0, done=0, cur_step=0. All table entries = {up=1, down=1, count=1}. Period counter=0. Edge-detect register=0.
- Table write: a write occurs when wr_en=1 and state=IDLE, at the clock edge. wr_en in any other state is ignored with no side effect. Table reads are combinational from registers.
- Edge detect: sq_prev <= sq_wave_in every cycle. rise = sq_wave_in & ~sq_prev. A rise marks the start of a new period.
- States:
  - IDLE: start=1 and stop=0 -> LOAD. Latch last_idx and loop_en; cur_step<=0.
  - LOAD (1 cycle): up/down <= entry[cur_step]; period counter<=0; busy=1 -> RUN.
  - RUN: on each rise, period counter increments. When a rise makes counter == max(count,1) of the current entry:
    - if cur_step != latched last_idx: cur_step<=cur_step+1 -> LOAD.
    - else if loop_en: cur_step<=0 -> LOAD.
    - else -> IDLE with done=1 for exactly that one cycle; up/down hold the last entry's values.
- Latency: rise sampled at cycle t -> state=LOAD at t+1 -> new up/down visible at t+2.
- stop: in LOAD or RUN, stop=1 -> IDLE next cycle; up/down <= 1/1; cur_step<=0; no done pulse. stop takes priority over a simultaneous advance or completion.
- start while busy is ignored. start and stop in the same cycle while IDLE: stop wins and the block remains in IDLE.
- last_idx latched >= DEPTH cannot occur (width-limited). With last_idx=0 the block runs a single entry.
- Counter arithmetic: CW-bit unsigned compare; count=0 is treated as 1, so the counter never wraps.
- Entries with up=0 or down=0 pass through unchanged. If sq_wave_in never rises, the block stays in RUN until stop or reset.
- Mid-operation reset: immediately returns all outputs to their reset values and clears the table.

Test Plan:
1. Reset, then start with default table, last_idx=0, loop_en=0 -> up=1, down=1, busy high. After the 1st sq_wave_in rise, done pulses 1 cycle, busy=0.
2. Write entries {4,1,2}, {2,3,3}; last_idx=1, loop_en=0; start -> up/down=4/1 until the 2nd rise. Then 2/3 appears 2 cycles after that rise, cur_step=1. done pulses on the 3rd rise of entry 1.
3. Same table with loop_en=1 -> after entry 1 completes, cur_step returns to 0 and up/down=4/1. busy stays high and done never pulses over 3 full loops.
4. stop asserted in the same cycle as the completing rise of entry 0 -> IDLE, up/down=1/1, cur_step=0, no done, no advance to entry 1.
5. wr_en to addr 0 with {7,7,5} while RUN -> table unchanged; a later run still applies the old entry 0. start pulsed during RUN -> ignored, cur_step unaffected.
6. Assert reset (0) mid-RUN, asynchronously between clock edges -> outputs at reset values immediately. The table reads back as {1,1,1} on the next run.

Source files
------------

// File: rtl/sq_wave_sequencer.sv
// -----------------------------------------------------------------------------
// sq_wave_sequencer
//
// Steps a programmable square wave generator through a small table of
// (on, off) interval settings. Each table entry is held for a programmed
// number of generator output periods. Period boundaries are found by
// watching the generator output for rising edges. New settings are applied
// only at those boundaries, so the waveform changes without glitches.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       asynchronous active-low reset (0 = reset)
//   wr_en       table write strobe, accepted only while idle
//   wr_addr     table entry index for a write
//   wr_up       on-interval value written to the entry
//   wr_down     off-interval value written to the entry
//   wr_count    periods to hold the entry (0 behaves as 1)
//   last_idx    index of the final step, captured on an accepted start
//   loop_en     1 = wrap to entry 0 after last_idx, captured on start
//   start       single-cycle start request (ignored while busy)
//   stop        abort request, wins over start and over step advance
//   sq_wave_in  generator output being monitored
//   up          on-interval value driven to the generator
//   down        off-interval value driven to the generator
//   busy        high while loading or running
//   done        one-cycle pulse when a non-looping sequence completes
//   cur_step    index of the table entry currently applied
// -----------------------------------------------------------------------------
module sq_wave_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    parameter int CW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_up,
    input  logic [W-1:0]  wr_down,
    input  logic [CW-1:0] wr_count,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    input  logic          sq_wave_in,
    output logic [W-1:0]  up,
    output logic [W-1:0]  down,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_step
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  up_q, up_d;
    logic [W-1:0]  down_q, down_d;
    logic [AW-1:0] step_q, step_d;
    logic [AW-1:0] last_q, last_d;
    logic          loop_q, loop_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_prev;

    // Settings table, read combinationally.
    logic [W-1:0]  tbl_up   [DEPTH];
    logic [W-1:0]  tbl_down [DEPTH];
    logic [CW-1:0] tbl_cnt  [DEPTH];

    logic          tbl_we;
    logic          rise;
    logic [CW-1:0] entry_cnt;
    logic [CW-1:0] target;
    logic [CW-1:0] cnt_inc;

    assign rise      = sq_wave_in & ~sq_prev;
    assign entry_cnt = tbl_cnt[step_q];
    // A zero count holds the entry for one period, so the counter never wraps.
    assign target    = (entry_cnt == '0) ? CW'(1) : entry_cnt;
    assign cnt_inc   = cnt_q + CW'(1);
    assign tbl_we    = wr_en && (state_q == S_IDLE);

    // NOTE: the table is reset because a cleared table must read back as
    // {1,1,1}; this costs a reset on every storage flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_up[i]   <= W'(1);
                tbl_down[i] <= W'(1);
                tbl_cnt[i]  <= CW'(1);
            end
        end else if (tbl_we) begin
            tbl_up[wr_addr]   <= wr_up;
            tbl_down[wr_addr] <= wr_down;
            tbl_cnt[wr_addr]  <= wr_count;
        end
    end

    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        down_d  = down_q;
        step_d  = step_q;
        last_d  = last_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    last_d  = last_idx;
                    loop_d  = loop_en;
                    step_d  = '0;
                end
            end

            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    up_d    = W'(1);
                    down_d  = W'(1);
                    step_d  = '0;
                end else begin
                    up_d    = tbl_up[step_q];
                    down_d  = tbl_down[step_q];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // Abort beats a simultaneous advance or completion.
                    state_d = S_IDLE;
                    up_d    = W'(1);
                    down_d  = W'(1);
                    step_d  = '0;
                end else if (rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == target) begin
                        if (step_q != last_q) begin
                            step_d  = step_q + AW'(1);
                            state_d = S_LOAD;
                        end else if (loop_q) begin
                            step_d  = '0;
                            state_d = S_LOAD;
                        end else begin
                            // up/down keep the final entry's values.
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            up_q    <= W'(1);
            down_q  <= W'(1);
            step_q  <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sq_prev <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            down_q  <= down_d;
            step_q  <= step_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            sq_prev <= sq_wave_in;
        end
    end

    assign up       = up_q;
    assign down     = down_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign cur_step = step_q;

endmodule
